// File: rtl/weight_limit_monitor.sv
// Elevator-car overload detector: counts synchronized rising edges of weight_flip,
// clears on rising edges of weight_flip_reset, and flags when the count exceeds LIMIT.
module weight_limit_monitor #(
    parameter int LIMIT       = 10,
    parameter int COUNT_W     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               weight_flip,
    input  logic               weight_flip_reset,
    output logic               weight_limit_exceeded,
    output logic [COUNT_W-1:0] weight_count
);

    localparam logic [COUNT_W-1:0] LIMIT_C = COUNT_W'(LIMIT);
    localparam logic [COUNT_W-1:0] MAX_C   = '1;

    logic [SYNC_STAGES-1:0] flip_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic                   flip_hist;
    logic                   clr_hist;
    logic                   flip_pulse;
    logic                   clr_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flip_sync <= '0;
            clr_sync  <= '0;
            flip_hist <= 1'b0;
            clr_hist  <= 1'b0;
        end else begin
            flip_sync <= {flip_sync[SYNC_STAGES-2:0], weight_flip};
            clr_sync  <= {clr_sync[SYNC_STAGES-2:0], weight_flip_reset};
            flip_hist <= flip_sync[SYNC_STAGES-1];
            clr_hist  <= clr_sync[SYNC_STAGES-1];
        end
    end

    assign flip_pulse = flip_sync[SYNC_STAGES-1] & ~flip_hist;
    assign clr_pulse  = clr_sync[SYNC_STAGES-1] & ~clr_hist;

    // Clear has priority: a flip arriving in the same cycle as a clear is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weight_count <= '0;
        end else if (clr_pulse) begin
            weight_count <= '0;
        end else if (flip_pulse && (weight_count != MAX_C)) begin
            weight_count <= weight_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weight_limit_exceeded <= 1'b0;
        end else begin
            weight_limit_exceeded <= (weight_count > LIMIT_C);
        end
    end

endmodule

// File: tb/tb_weight_limit_monitor.sv
// Directed self-checking bench for weight_limit_monitor: boundary, clear, priority,
// level hold, async reset, and saturation on a narrow-counter instance.
module tb_weight_limit_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       flip1, clr1, flip2, clr2;
    logic       flag1, flag2;
    logic [7:0] count1;
    logic [3:0] count2;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    weight_limit_monitor #(.LIMIT(10), .COUNT_W(8), .SYNC_STAGES(2)) dut1 (
        .clk                  (clk),
        .reset                (reset),
        .weight_flip          (flip1),
        .weight_flip_reset    (clr1),
        .weight_limit_exceeded(flag1),
        .weight_count         (count1)
    );

    weight_limit_monitor #(.LIMIT(10), .COUNT_W(4), .SYNC_STAGES(2)) dut2 (
        .clk                  (clk),
        .reset                (reset),
        .weight_flip          (flip2),
        .weight_flip_reset    (clr2),
        .weight_limit_exceeded(flag2),
        .weight_count         (count2)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic rise1(input int n);
        for (int i = 0; i < n; i++) begin
            flip1 = 1'b1;
            tick(4);
            flip1 = 1'b0;
            tick(4);
        end
    endtask

    task automatic rise2(input int n);
        for (int i = 0; i < n; i++) begin
            flip2 = 1'b1;
            tick(4);
            flip2 = 1'b0;
            tick(4);
        end
    endtask

    initial begin
        reset = 1'b1;
        flip1 = 1'b0; clr1 = 1'b0; flip2 = 1'b0; clr2 = 1'b0;
        tick(3);
        check("reset_count1", 32'(count1), 32'd0);
        check("reset_flag1",  32'(flag1),  32'd0);
        check("reset_count2", 32'(count2), 32'd0);
        reset = 1'b0;
        tick(2);

        // Boundary: ten events sit exactly at LIMIT, flag stays low
        rise1(1);
        check("first_rise", 32'(count1), 32'd1);
        rise1(9);
        check("count_at_limit", 32'(count1), 32'd10);
        check("flag_at_limit",  32'(flag1),  32'd0);

        // Eleventh rise, cycle-accurate latency
        flip1 = 1'b1;
        tick(1);
        tick(1);
        check("lat_n1_count", 32'(count1), 32'd10);
        tick(1);
        check("lat_n2_count", 32'(count1), 32'd11);
        check("lat_n2_flag",  32'(flag1),  32'd0);
        tick(1);
        check("lat_n3_flag",  32'(flag1),  32'd1);
        flip1 = 1'b0;
        tick(4);
        check("fall_no_effect", 32'(count1), 32'd11);

        rise1(1);
        check("count12", 32'(count1), 32'd12);
        check("flag12",  32'(flag1),  32'd1);

        // Clear with cycle-accurate latency
        clr1 = 1'b1;
        tick(1);
        tick(1);
        check("clr_n1_count", 32'(count1), 32'd12);
        tick(1);
        check("clr_n2_count", 32'(count1), 32'd0);
        check("clr_n2_flag",  32'(flag1),  32'd1);
        tick(1);
        check("clr_n3_flag",  32'(flag1),  32'd0);
        clr1 = 1'b0;
        tick(4);
        check("clr_fall", 32'(count1), 32'd0);
        rise1(1);
        check("after_clr_rise", 32'(count1), 32'd1);

        // Simultaneous flip and clear: clear wins
        rise1(6);
        check("count7", 32'(count1), 32'd7);
        flip1 = 1'b1; clr1 = 1'b1;
        tick(6);
        check("simul_count", 32'(count1), 32'd0);
        check("simul_flag",  32'(flag1),  32'd0);
        flip1 = 1'b0; clr1 = 1'b0;
        tick(4);
        check("simul_fall", 32'(count1), 32'd0);

        // Level hold gives exactly one increment
        flip1 = 1'b1;
        tick(50);
        check("hold_count", 32'(count1), 32'd1);
        flip1 = 1'b0;
        tick(10);
        check("hold_fall", 32'(count1), 32'd1);

        // Async reset mid-count, between clock edges
        rise1(4);
        check("pre_reset_count", 32'(count1), 32'd5);
        #3;
        reset = 1'b1;
        #1;
        check("async_count1", 32'(count1), 32'd0);
        check("async_flag1",  32'(flag1),  32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);

        // Saturation on the 4-bit instance
        rise2(11);
        check("sat_count11", 32'(count2), 32'd11);
        check("sat_flag11",  32'(flag2),  32'd1);
        rise2(9);
        check("sat_count20", 32'(count2), 32'd15);
        check("sat_flag20",  32'(flag2),  32'd1);
        check("dut1_idle",   32'(count1), 32'd0);

        // Async reset clears a set flag immediately
        #3;
        reset = 1'b1;
        #1;
        check("async_count2", 32'(count2), 32'd0);
        check("async_flag2",  32'(flag2),  32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
